// File: rtl/host_mem_responder.sv
// Host-side memory endpoint: word-addressed array answering read/write beat handshakes with
// programmable latency. Define MEM_STATS_EN to add saturating read/write beat counters.
module host_mem_responder #(
    parameter int unsigned MEM_WORDS = 16384,
    parameter int unsigned ADDR_WID  = 14,
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter int unsigned RD_LAT    = 4,
    parameter int unsigned WR_LAT    = 4,
    parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_read_enable,
    input  logic [63:0]         i_read_addr,
    input  logic                i_finish_read,
    output logic [63:0]         o_read_ready,
    output logic [31:0]         o_read_data,
    input  logic                i_write_enable,
    input  logic [63:0]         i_write_addr,
    input  logic [31:0]         i_write_data,
    input  logic                i_finish_write,
    output logic [63:0]         o_write_ready,
    input  logic                i_init_we,
    input  logic [ADDR_WID-1:0] i_init_addr,
    input  logic [31:0]         i_init_data,
    output logic                o_addr_err
`ifdef MEM_STATS_EN
    ,
    output logic [31:0]         o_rd_beats,
    output logic [31:0]         o_wr_beats
`endif
);

    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP, R_HOLD} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP, W_HOLD} wr_state_e;

    logic [31:0] r_mem [MEM_WORDS];

    rd_state_e   r_rd_state;
    logic [63:0] r_rd_addr;
    logic [15:0] r_rd_cnt;
    logic        r_read_ready;
    logic [31:0] r_read_data;

    wr_state_e   r_wr_state;
    logic [63:0] r_wr_addr;
    logic [31:0] r_wr_data;
    logic [15:0] r_wr_cnt;
    logic        r_write_ready;

    logic        r_addr_err;

    logic [63:0]         w_rd_off;
    logic [63:0]         w_wr_off;
    logic                w_rd_in_range;
    logic                w_wr_in_range;
    logic [ADDR_WID-1:0] w_rd_idx;
    logic [ADDR_WID-1:0] w_wr_idx;
    logic                w_rd_fire;
    logic                w_wr_fire;
    logic                w_wr_commit;

    // Range test is a 64-bit unsigned window check on the byte address.
    assign w_rd_off      = r_rd_addr - BASE_ADDR;
    assign w_wr_off      = r_wr_addr - BASE_ADDR;
    assign w_rd_in_range = (r_rd_addr >= BASE_ADDR) && (w_rd_off < MEM_BYTES);
    assign w_wr_in_range = (r_wr_addr >= BASE_ADDR) && (w_wr_off < MEM_BYTES);
    assign w_rd_idx      = w_rd_off[ADDR_WID+1:2];
    assign w_wr_idx      = w_wr_off[ADDR_WID+1:2];
    assign w_rd_fire     = (r_rd_state == R_WAIT) && (r_rd_cnt == 16'(RD_LAT - 1));
    assign w_wr_fire     = (r_wr_state == W_WAIT) && (r_wr_cnt == 16'(WR_LAT - 1));
    assign w_wr_commit   = w_wr_fire && w_wr_in_range;

    // Commit is ordered after the backdoor so a same-word collision keeps the beat data.
    always_ff @(posedge i_clk) begin
        if (i_init_we) r_mem[i_init_addr] <= i_init_data;
        if (w_wr_commit) r_mem[w_wr_idx] <= r_wr_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_state   <= R_IDLE;
            r_rd_addr    <= '0;
            r_rd_cnt     <= '0;
            r_read_ready <= 1'b0;
            r_read_data  <= '0;
        end else begin
            r_read_ready <= 1'b0;
            unique case (r_rd_state)
                R_IDLE: if (i_read_enable) begin
                    r_rd_addr  <= i_read_addr;
                    r_rd_cnt   <= '0;
                    r_rd_state <= R_WAIT;
                end
                R_WAIT: if (w_rd_fire) begin
                    r_rd_state   <= R_RESP;
                    r_read_ready <= 1'b1;
                    r_read_data  <= w_rd_in_range ? r_mem[w_rd_idx] : ERR_DATA;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 16'd1;
                end
                R_RESP: r_rd_state <= R_HOLD;
                R_HOLD: if (i_finish_read && i_read_enable) begin
                    r_rd_addr  <= i_read_addr;
                    r_rd_cnt   <= '0;
                    r_rd_state <= R_WAIT;
                end else if (!i_read_enable) begin
                    r_rd_state <= R_IDLE;
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_state    <= W_IDLE;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_wr_cnt      <= '0;
            r_write_ready <= 1'b0;
        end else begin
            r_write_ready <= 1'b0;
            unique case (r_wr_state)
                W_IDLE: if (i_write_enable) begin
                    r_wr_addr  <= i_write_addr;
                    r_wr_data  <= i_write_data;
                    r_wr_cnt   <= '0;
                    r_wr_state <= W_WAIT;
                end
                W_WAIT: if (w_wr_fire) begin
                    r_wr_state    <= W_RESP;
                    r_write_ready <= 1'b1;
                end else begin
                    r_wr_cnt <= r_wr_cnt + 16'd1;
                end
                W_RESP: r_wr_state <= W_HOLD;
                W_HOLD: if (i_finish_write && i_write_enable) begin
                    r_wr_addr  <= i_write_addr;
                    r_wr_data  <= i_write_data;
                    r_wr_cnt   <= '0;
                    r_wr_state <= W_WAIT;
                end else if (!i_write_enable) begin
                    r_wr_state <= W_IDLE;
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr_err <= 1'b0;
        end else if ((w_rd_fire && !w_rd_in_range) || (w_wr_fire && !w_wr_in_range)) begin
            r_addr_err <= 1'b1;
        end
    end

`ifdef MEM_STATS_EN
    logic [31:0] r_rd_beats;
    logic [31:0] r_wr_beats;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rd_beats <= '0;
            r_wr_beats <= '0;
        end else begin
            if (w_rd_fire && (r_rd_beats != 32'hFFFF_FFFF)) r_rd_beats <= r_rd_beats + 32'd1;
            if (w_wr_fire && (r_wr_beats != 32'hFFFF_FFFF)) r_wr_beats <= r_wr_beats + 32'd1;
        end
    end

    assign o_rd_beats = r_rd_beats;
    assign o_wr_beats = r_wr_beats;
`endif

    assign o_read_ready  = {63'd0, r_read_ready};
    assign o_write_ready = {63'd0, r_write_ready};
    assign o_read_data   = r_read_data;
    assign o_addr_err    = r_addr_err;

endmodule

// File: doc/host_mem_responder.md
Name: host_mem_responder

Overview:
- Host-side memory endpoint that sits directly upstream of the scratchpad accelerator wrapper.
- Answers the wrapper's read and write requests, both the burst fill/drain phases and the single-beat cache-miss accesses, using the read_enable/read_ready/finish_read handshake and its write-side mirror.
- Holds a word-addressed backing array with programmable response latency.
- Used as the DRAM/host model in simulation and as the on-FPGA host buffer in standalone builds.

Parameters:
- MEM_WORDS, 16384: backing array depth in 32-bit words. Power of two.
- ADDR_WID, 14: log2(MEM_WORDS).
- BASE_ADDR, 64'd0: byte address of word 0.
- RD_LAT, 4: cycles from request acceptance to the read_ready pulse. Must be >=1.
- WR_LAT, 4: cycles from request acceptance to the write_ready pulse. Must be >=1.
- ERR_DATA, 32'hDEADBEEF: data returned for out-of-range reads.

Ports:
- clk in 1: clock.
- reset in 1: asynchronous, active-high reset.
- read_enable in 1: read request / burst active.
- read_addr in 64: byte address of the current read beat.
- finish_read in 1: one-cycle pulse meaning the current beat is consumed and read_addr now holds the next beat.
- read_ready out 64: equals 1 for exactly one cycle when read_data is valid, otherwise 0.
- read_data out 32: read beat data.
- write_enable in 1: write request / burst active.
- write_addr in 64: byte address of the current write beat.
- write_data in 32: write beat data.
- finish_write in 1: one-cycle pulse meaning the next write beat is presented.
- write_ready out 64: equals 1 for exactly one cycle when the beat is committed, otherwise 0.
- init_we in 1: backdoor preload write enable.
- init_addr in ADDR_WID: backdoor word index.
- init_data in 32: backdoor data.
- addr_err out 1: sticky out-of-range flag.

Behaviour:
- Reset (asynchronous): read_ready=0, write_ready=0, read_data=0, addr_err=0, both FSMs to IDLE, latency counters=0. Array contents are not reset.
- Word index = (addr - BASE_ADDR) >> 2, truncated to ADDR_WID bits.
- In range means BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS. The subtraction is a 64-bit unsigned comparison.
- Read FSM states: R_IDLE, R_WAIT, R_RESP, R_HOLD.
  - R_IDLE: read_enable=1 latches read_addr, clears the counter, goes to R_WAIT.
  - R_WAIT: counter increments; when it reaches RD_LAT-1, go to R_RESP.
  - R_RESP (one cycle): read_ready=1; read_data = array[index], or ERR_DATA if out of range; out of range also sets addr_err. Go to R_HOLD.
  - R_HOLD: finish_read=1 with read_enable=1 latches the new read_addr and goes to R_WAIT. read_enable=0 goes to R_IDLE. Otherwise stay.
- A request latched on a single-cycle read_enable pulse (enable drops while in R_WAIT) still completes: read_ready is pulsed once, then R_HOLD sees read_enable=0 and returns to R_IDLE.
- Read-ready-to-next-ready spacing within a burst is RD_LAT+2 cycles minimum: the requester pulses finish_read one cycle after read_ready.
- finish_read in any state other than R_HOLD is ignored.
- Write FSM states: W_IDLE, W_WAIT, W_RESP, W_HOLD, mirroring the read FSM with WR_LAT.
  - Address and data are latched on acceptance.
  - W_RESP writes the array (in range only; out of range sets addr_err and is dropped) and pulses write_ready=1.
- The read and write FSMs are independent and may be active in the same cycle.
- Same-cycle read sample and write commit to the same word: the read returns the old data.
- Backdoor port init_we: writes array[init_addr] immediately. Legal only while both FSMs are idle. If it collides with a W_RESP commit to the same word, the W_RESP data wins.
- Reset mid-burst: FSMs abort immediately; a pending beat is not committed; no ready pulse is emitted after reset.
- read_ready and write_ready are zero-extended: bits 63:1 are always 0.

Optional Feature:
- Macro MEM_STATS_EN.
- When defined: adds outputs rd_beats (out 32) and wr_beats (out 32), both reset to 0.
  - rd_beats increments on each read_ready pulse.
  - wr_beats increments on each write_ready pulse, including dropped out-of-range writes.
  - Both saturate at 32'hFFFFFFFF.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single read: preload word 5 = 32'h1234; with RD_LAT=4, pulse read_enable for one cycle at addr BASE+20 -> read_ready==1 exactly 4 cycles after the acceptance edge, read_data=32'h1234, a single pulse, FSM back to R_IDLE.
- Read burst of 8 beats: hold read_enable; the requester pulses finish_read and advances the address by 4 after each read_ready -> eight pulses returning words 0..7 in order, with spacing of 6 cycles.
- Write burst of 4 beats: data A0..A3 at BASE+0..12 with WR_LAT=2 -> four write_ready pulses; a subsequent read burst returns A0..A3.
- Out of range: read at BASE+4*MEM_WORDS -> read_data=32'hDEADBEEF and addr_err=1, sticky until reset; an out-of-range write leaves the array unchanged.
- Concurrent traffic plus collision: read and write to word 9 with ready pulses landing in the same cycle -> read returns the old value; a later read returns the new value.
- Reset mid-burst: assert reset during R_WAIT of beat 3 -> outputs go to 0 immediately with no further ready pulse; with MEM_STATS_EN, rd_beats=0 after reset.
